// File: rtl/dual_port_ram_ctrl_if.sv
// Port bundle for dual_port_ram_ctrl: per-port request/response signals plus busy and collision.
interface dual_port_ram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              busy;
    logic              collision;

    logic              a_en;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_dout;
    logic              a_rvalid;

    logic              b_en;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] b_dout;
    logic              b_rvalid;

    modport master (
        output a_en, a_we, a_addr, a_din,
        output b_en, b_we, b_addr, b_din,
        input  a_dout, a_rvalid, b_dout, b_rvalid, busy, collision
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din,
        input  b_en, b_we, b_addr, b_din,
        output a_dout, a_rvalid, b_dout, b_rvalid, busy, collision
    );
endinterface

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port RAM with clear-on-reset sequencer and write/write collision flag.
// Define DPRAM_OUT_REG_EN to add an output register stage per port (read latency 2).
module dual_port_ram_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    dual_port_ram_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] a_dout_r;
    logic [DATA_W-1:0] b_dout_r;
    logic              a_rvalid_r;
    logic              b_rvalid_r;
    logic              collision_r;
    logic              busy_r;

    logic              a_wr;
    logic              b_wr;

    assign a_wr = bus.a_en && bus.a_we;
    assign b_wr = bus.b_en && bus.b_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            busy_r      <= 1'b1;
            a_dout_r    <= '0;
            b_dout_r    <= '0;
            a_rvalid_r  <= 1'b0;
            b_rvalid_r  <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                    a_rvalid_r   <= 1'b0;
                    b_rvalid_r   <= 1'b0;
                    collision_r  <= 1'b0;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state  <= READY;
                        busy_r <= 1'b0;
                    end
                end
                READY: begin
                    // B is written first so that A's data survives a same-address write/write.
                    if (b_wr) mem[bus.b_addr] <= bus.b_din;
                    if (a_wr) mem[bus.a_addr] <= bus.a_din;

                    if (bus.a_en) begin
                        if (bus.a_we) begin
                            if (RDW_MODE == 1) begin
                                a_dout_r   <= bus.a_din;
                                a_rvalid_r <= 1'b1;
                            end else begin
                                a_rvalid_r <= 1'b0;
                            end
                        end else begin
                            a_dout_r   <= mem[bus.a_addr];
                            a_rvalid_r <= 1'b1;
                        end
                    end else begin
                        a_rvalid_r <= 1'b0;
                    end

                    if (bus.b_en) begin
                        if (bus.b_we) begin
                            if (RDW_MODE == 1) begin
                                b_dout_r   <= bus.b_din;
                                b_rvalid_r <= 1'b1;
                            end else begin
                                b_rvalid_r <= 1'b0;
                            end
                        end else begin
                            b_dout_r   <= mem[bus.b_addr];
                            b_rvalid_r <= 1'b1;
                        end
                    end else begin
                        b_rvalid_r <= 1'b0;
                    end

                    collision_r <= a_wr && b_wr && (bus.a_addr == bus.b_addr);
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.busy = busy_r;

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_W-1:0] a_dout_q;
    logic [DATA_W-1:0] b_dout_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic              collision_q;

    // Second stage mirrors the first so rvalid, dout and collision stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q    <= '0;
            b_dout_q    <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_dout_q    <= a_dout_r;
            b_dout_q    <= b_dout_r;
            a_rvalid_q  <= a_rvalid_r;
            b_rvalid_q  <= b_rvalid_r;
            collision_q <= collision_r;
        end
    end

    assign bus.a_dout    = a_dout_q;
    assign bus.b_dout    = b_dout_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.collision = collision_q;
`else
    assign bus.a_dout    = a_dout_r;
    assign bus.b_dout    = b_dout_r;
    assign bus.a_rvalid  = a_rvalid_r;
    assign bus.b_rvalid  = b_rvalid_r;
    assign bus.collision = collision_r;
`endif

endmodule
